// File: rtl/fifo_pkg.sv
// Shared helpers for the sync_fifo family: width derivation used by the top and RAM.
package fifo_pkg;

  // Bits needed to hold the values 0..depth inclusive.
  function automatic int f_cnt_w(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << w) < depth + 1) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage for sync_fifo; the read port is either combinational
// (LUTRAM-friendly) or registered with a read enable (maps to BSRAM output register).
module fifo_ram #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8,
  parameter bit REG_RD     = 1'b0,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[waddr_i] <= wdata_i;
  end

  generate
    if (REG_RD) begin : g_reg_rd
      logic [DATA_WIDTH-1:0] r_rdata;
      // Only the output register is reset; the array contents survive reset.
      always_ff @(posedge clk_i) begin
        if (rst_i)     r_rdata <= '0;
        else if (re_i) r_rdata <= r_mem[raddr_i];
      end
      assign rdata_o = r_rdata;
    end else begin : g_comb_rd
      logic w_unused;
      assign w_unused = &{1'b0, rst_i, re_i};
      assign rdata_o  = r_mem[raddr_i];
    end
  endgenerate

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO of arbitrary depth with occupancy count, threshold flags,
// sticky error flags and a choice of first-word-fall-through or registered read.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter bit FWFT       = 1'b1,
  parameter int PTR_W      = $clog2(DEPTH),
  parameter int CNT_W      = f_cnt_w(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  rd_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  almost_empty_o,
  output logic                  almost_full_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  input  logic                  clr_err_i
);

  generate
    if (DEPTH < 2) begin : g_bad_depth
      $error("sync_fifo: DEPTH must be >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
      $error("sync_fifo: AF_LEVEL must be in 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL >= DEPTH) begin : g_bad_ae
      $error("sync_fifo: AE_LEVEL must be in 0..DEPTH-1");
    end
  endgenerate

  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_AF  = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] C_AE  = CNT_W'(AE_LEVEL);

  logic [PTR_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf, r_unf;
  logic             w_empty, w_full, w_wr_acc, w_rd_acc;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == C_MAX);
  assign w_wr_acc = wr_i & ~w_full;
  assign w_rd_acc = rd_i & ~w_empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      // Explicit wrap so non-power-of-two depths never address past DEPTH-1.
      if (w_wr_acc) r_head <= (r_head == LAST) ? '0 : r_head + 1'b1;
      if (w_rd_acc) r_tail <= (r_tail == LAST) ? '0 : r_tail + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A new error event takes priority over a coincident clear.
      r_ovf <= (wr_i & w_full)  | (r_ovf & ~clr_err_i);
      r_unf <= (rd_i & w_empty) | (r_unf & ~clr_err_i);
    end
  end

  fifo_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .REG_RD     (!FWFT),
    .AW         (PTR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (w_wr_acc),
    .waddr_i (r_head),
    .wdata_i (wdata_i),
    .re_i    (w_rd_acc),
    .raddr_i (r_tail),
    .rdata_o (rdata_o)
  );

  generate
    if (FWFT) begin : g_fwft
      assign rvalid_o = ~w_empty;
    end else begin : g_regrd
      logic r_rvalid;
      always_ff @(posedge clk_i) begin
        if (rst_i) r_rvalid <= 1'b0;
        else       r_rvalid <= w_rd_acc;
      end
      assign rvalid_o = r_rvalid;
    end
  endgenerate

  assign empty_o        = w_empty;
  assign full_o         = w_full;
  assign almost_empty_o = (r_count <= C_AE);
  assign almost_full_o  = (r_count >= C_AF);
  assign count_o        = r_count;
  assign overflow_o     = r_ovf;
  assign underflow_o    = r_unf;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: three instances cover FWFT depth 16, a depth-5 wrap case,
// and the registered-read mode.
module tb_sync_fifo;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // A: DEPTH=16, AF=12, AE=2, FWFT
  logic       a_wr = 0, a_rd = 0;
  logic [7:0] a_wd = 0, a_rdata;
  logic       a_rv, a_em, a_fu, a_ae, a_af, a_ov, a_un;
  logic [4:0] a_cnt;
  // B: DEPTH=5, FWFT
  logic       b_wr = 0, b_rd = 0;
  logic [7:0] b_wd = 0, b_rdata;
  logic       b_rv, b_em, b_fu, b_ae, b_af, b_ov, b_un;
  logic [2:0] b_cnt;
  // C: DEPTH=16, registered read
  logic       c_wr = 0, c_rd = 0;
  logic [7:0] c_wd = 0, c_rdata;
  logic       c_rv, c_em, c_fu, c_ae, c_af, c_ov, c_un;
  logic [4:0] c_cnt;

  sync_fifo #(.DEPTH(16), .DATA_WIDTH(8), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(1'b1)) u_a (
    .clk_i(clk), .rst_i(rst), .wr_i(a_wr), .wdata_i(a_wd), .rd_i(a_rd), .rdata_o(a_rdata),
    .rvalid_o(a_rv), .empty_o(a_em), .full_o(a_fu), .almost_empty_o(a_ae), .almost_full_o(a_af),
    .count_o(a_cnt), .overflow_o(a_ov), .underflow_o(a_un), .clr_err_i(clr));

  sync_fifo #(.DEPTH(5), .DATA_WIDTH(8), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1'b1)) u_b (
    .clk_i(clk), .rst_i(rst), .wr_i(b_wr), .wdata_i(b_wd), .rd_i(b_rd), .rdata_o(b_rdata),
    .rvalid_o(b_rv), .empty_o(b_em), .full_o(b_fu), .almost_empty_o(b_ae), .almost_full_o(b_af),
    .count_o(b_cnt), .overflow_o(b_ov), .underflow_o(b_un), .clr_err_i(clr));

  sync_fifo #(.DEPTH(16), .DATA_WIDTH(8), .FWFT(1'b0)) u_c (
    .clk_i(clk), .rst_i(rst), .wr_i(c_wr), .wdata_i(c_wd), .rd_i(c_rd), .rdata_o(c_rdata),
    .rvalid_o(c_rv), .empty_o(c_em), .full_o(c_fu), .almost_empty_o(c_ae), .almost_full_o(c_af),
    .count_o(c_cnt), .overflow_o(c_ov), .underflow_o(c_un), .clr_err_i(clr));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #1;
    rst = 1; tick(); rst = 0;
    chk("rst_empty", a_em, 1); chk("rst_full", a_fu, 0);
    chk("rst_ae", a_ae, 1);    chk("rst_af", a_af, 0);
    chk("rst_cnt", a_cnt, 0);  chk("rst_ovf", a_ov, 0);
    chk("rst_unf", a_un, 0);   chk("rst_rvalid", a_rv, 0);
    chk("rst_c_rdata", c_rdata, 0); chk("rst_c_rvalid", c_rv, 0);

    // Fill and drain with threshold tracking
    for (int i = 0; i < 16; i++) begin
      a_wr = 1; a_wd = 8'(i); tick();
      chk("fill_cnt", a_cnt, i + 1);
      chk("fill_ae", a_ae, (i + 1) <= 2);
      chk("fill_af", a_af, (i + 1) >= 12);
    end
    a_wr = 0;
    chk("fill_full", a_fu, 1);
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", a_rdata, i); chk("drain_rvalid", a_rv, 1);
      a_rd = 1; tick();
      chk("drain_cnt", a_cnt, 15 - i);
      chk("drain_ae", a_ae, (15 - i) <= 2);
      chk("drain_af", a_af, (15 - i) >= 12);
    end
    a_rd = 0;
    chk("drain_empty", a_em, 1); chk("drain_rvalid0", a_rv, 0);

    // Simultaneous read/write at count 3
    for (int i = 0; i < 3; i++) begin a_wr = 1; a_wd = 8'(8'h10 + i); tick(); end
    for (int k = 0; k < 10; k++) begin
      a_wr = 1; a_rd = 1; a_wd = 8'(8'h13 + k);
      chk("sim_data", a_rdata, 8'h10 + k);
      tick();
      chk("sim_cnt", a_cnt, 3);
    end
    a_wr = 0;
    for (int i = 0; i < 3; i++) begin chk("sim_tail", a_rdata, 8'h1A + i); tick(); end
    a_rd = 0;
    chk("sim_empty", a_em, 1);

    // rd+wr while full: read only, overflow set
    for (int i = 0; i < 16; i++) begin a_wr = 1; a_wd = 8'(8'h20 + i); tick(); end
    a_rd = 1; a_wd = 8'h77; tick(); a_wr = 0; a_rd = 0;
    chk("full_rw_cnt", a_cnt, 15); chk("full_rw_ovf", a_ov, 1);
    for (int i = 0; i < 15; i++) begin
      chk("full_rw_data", a_rdata, 8'h21 + i); a_rd = 1; tick();
    end
    a_rd = 0;
    // rd+wr while empty: write only, underflow set
    a_wr = 1; a_rd = 1; a_wd = 8'h33; tick(); a_wr = 0; a_rd = 0;
    chk("empty_rw_cnt", a_cnt, 1); chk("empty_rw_unf", a_un, 1);
    chk("empty_rw_data", a_rdata, 8'h33);
    a_rd = 1; tick(); a_rd = 0;
    clr = 1; tick(); clr = 0;
    chk("clr_ovf", a_ov, 0); chk("clr_unf", a_un, 0);

    // Overflow stickiness, set-beats-clear, memory untouched
    for (int i = 0; i < 16; i++) begin a_wr = 1; a_wd = 8'(8'h40 + i); tick(); end
    a_wd = 8'hAA; tick(); a_wr = 0;
    chk("ovf_set", a_ov, 1); chk("ovf_cnt", a_cnt, 16);
    tick();
    chk("ovf_sticky", a_ov, 1);
    a_wr = 1; a_wd = 8'hAB; clr = 1; tick(); a_wr = 0;
    chk("ovf_set_wins", a_ov, 1);
    tick(); clr = 0;
    chk("ovf_cleared", a_ov, 0);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_drain", a_rdata, 8'h40 + i); a_rd = 1; tick();
    end
    a_rd = 0;

    // Depth-5 wrap across three rounds
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) begin
        b_wr = 1; b_wd = 8'(r * 5 + i + 1); tick();
        chk("wrap_cnt_up", b_cnt, i + 1);
      end
      b_wr = 0;
      chk("wrap_full", b_fu, 1);
      for (int i = 0; i < 5; i++) begin
        chk("wrap_data", b_rdata, r * 5 + i + 1); b_rd = 1; tick();
        chk("wrap_cnt_dn", b_cnt, 4 - i);
      end
      b_rd = 0;
    end

    // Registered-read mode
    c_rd = 1; tick(); c_rd = 0;
    chk("c_unf", c_un, 1); chk("c_unf_rvalid", c_rv, 0);
    c_wr = 1; c_wd = 8'h5A; tick(); c_wr = 0;
    chk("c_wr_cnt", c_cnt, 1); chk("c_wr_empty", c_em, 0); chk("c_wr_rvalid", c_rv, 0);
    c_rd = 1; tick(); c_rd = 0;
    chk("c_rd_rvalid", c_rv, 1); chk("c_rd_data", c_rdata, 8'h5A); chk("c_rd_empty", c_em, 1);
    tick();
    chk("c_rvalid_pulse", c_rv, 0); chk("c_rdata_hold", c_rdata, 8'h5A);
    for (int i = 0; i < 7; i++) begin c_wr = 1; c_wd = 8'(8'h60 + i); tick(); end
    c_wr = 0;
    chk("c_cnt7", c_cnt, 7);
    rst = 1; c_rd = 1; c_wr = 1; c_wd = 8'hEE; tick();
    rst = 0; c_rd = 0; c_wr = 0;
    chk("c_rst_cnt", c_cnt, 0);   chk("c_rst_empty", c_em, 1);
    chk("c_rst_unf", c_un, 0);    chk("c_rst_ovf", c_ov, 0);
    chk("c_rst_rvalid", c_rv, 0); chk("c_rst_rdata", c_rdata, 0);
    chk("c_rst_ae", c_ae, 1);     chk("c_rst_af", c_af, 0);
    c_wr = 1; c_wd = 8'h99; tick(); c_wr = 0;
    c_rd = 1; tick(); c_rd = 0;
    chk("c_post_rvalid", c_rv, 1); chk("c_post_data", c_rdata, 8'h99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Parametrised single-clock FIFO; successor to the basic ring buffer.
- Adds:
  - arbitrary depth (not only powers of two)
  - occupancy count
  - programmable almost-full / almost-empty flags
  - selectable first-word-fall-through or registered-read mode
  - sticky overflow/underflow error flags
- Sits between UART/SPI/audio producers and consumers in the Tang Nano 9K design; maps the storage to BSRAM or LUTRAM.

Parameters:
- DEPTH, 16, number of entries; any integer >= 2.
- DATA_WIDTH, 8, bits per entry.
- AF_LEVEL, DEPTH-2, almost_full_o asserted when count >= AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, 2, almost_empty_o asserted when count <= AE_LEVEL; range 0..DEPTH-1.
- FWFT, 1, 1 = head word visible on rdata_o while not empty; 0 = registered read, data valid one cycle after accepted read.
- PTR_W, $clog2(DEPTH), pointer width (derived; not overridden).
- CNT_W, $clog2(DEPTH+1), count width (derived; not overridden).

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- wr_i  in  1  write request.
- wdata_i  in  DATA_WIDTH  write data.
- rd_i  in  1  read request.
- rdata_o  out  DATA_WIDTH  read data.
- rvalid_o  out  1  FWFT=1: equals !empty_o. FWFT=0: one-cycle pulse, rdata_o valid.
- empty_o  out  1  count == 0.
- full_o  out  1  count == DEPTH.
- almost_empty_o  out  1  count <= AE_LEVEL.
- almost_full_o  out  1  count >= AF_LEVEL.
- count_o  out  CNT_W  current occupancy.
- overflow_o  out  1  sticky: write attempted while full.
- underflow_o  out  1  sticky: read attempted while empty.
- clr_err_i  in  1  clears overflow_o and underflow_o.

Behaviour:
- Reset (rst_i=1 at clock edge):
  - head, tail and count = 0.
  - empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0.
  - overflow_o=0, underflow_o=0, rvalid_o=0.
  - rdata_o=0 in FWFT=0 mode; undefined in FWFT=1 mode.
  - Memory contents are not cleared.
  - Reset wins over every other input in the same cycle.
- Write accept: wr_i && !full_o. Stores wdata_i at head; head advances.
- Read accept: rd_i && !empty_o. Tail advances.
- Pointer wrap: a pointer equal to DEPTH-1 wraps to 0 (explicit compare, not modulo-2^PTR_W).
- Count is a registered counter:
  - +1 on write only, -1 on read only.
  - Unchanged when both are accepted or neither is.
  - All status flags are derived combinationally from the registered count, so they update in the cycle after the accepted operation.
- Simultaneous rd_i and wr_i:
  - Not full, not empty: both accepted, count unchanged.
  - Full: read accepted, write rejected, overflow_o sets. No pass-through.
  - Empty: write accepted, read rejected, underflow_o sets. No bypass; data is readable next cycle.
- Rejected ops never modify memory, pointers or count.
- Error flags:
  - overflow_o sets on wr_i while full_o; underflow_o sets on rd_i while empty_o.
  - Both hold until clr_err_i or reset.
  - If a set event coincides with clr_err_i, set wins.
- FWFT=1:
  - rdata_o = mem[tail] combinationally.
  - Read latency 0: data is present with rvalid_o before rd_i is asserted.
- FWFT=0:
  - On accepted read, rdata_o <= mem[tail] at that edge; rvalid_o=1 for exactly the following cycle.
  - Otherwise rvalid_o=0 and rdata_o holds its last value.
- Write-to-read latency (empty FIFO, write at edge N):
  - FWFT=1: empty_o=0 after edge N, and the word is visible on rdata_o.
  - FWFT=0: the earliest accepted read is at edge N+1; data is visible after edge N+1.
- Parameter legality: elaboration-time assertions for DEPTH>=2, 1<=AF_LEVEL<=DEPTH, 0<=AE_LEVEL<DEPTH.

Decomposition:
- Package fifo_pkg: a function computing count width from depth.
- Pointers are parameter-sized logic vectors declared locally (parameter-dependent, not in the package).
- Sub-module fifo_ram:
  - Simple dual-port storage, one write port, one read port.
  - Parameters DEPTH, DATA_WIDTH.
  - Read port has a comb (FWFT) or registered (non-FWFT) option so synthesis infers BSRAM for FWFT=0.
- All control (pointers, count, flags) stays in sync_fifo.

Test Plan:
- Fill and drain, DEPTH=16 W=8: write 0x00..0x0F, then read 16. Reads return 0x00..0x0F in order. full_o=1 after write 16; empty_o=1 after read 16; count_o walks 0->16->0.
- Non-power-of-two wrap, DEPTH=5: three rounds of write 5 / read 5 with values 1..15. Order is preserved across the wrap from pointer 4 to 0; count_o never exceeds 5.
- Simultaneous ops: at count=3, hold rd_i=wr_i=1 for 10 cycles. count_o stays 3 and output order is preserved. At full, rd+wr gives count 15 and overflow_o=1. At empty, rd+wr gives count 1 and underflow_o=1.
- Thresholds, AF_LEVEL=12, AE_LEVEL=2:
  - almost_empty_o deasserts after the 3rd write and reasserts when count returns to 2.
  - almost_full_o asserts when count_o reaches 12 and deasserts at 11.
- Errors: write 0xAA when full. overflow_o=1 and sticky; memory unchanged (a drain shows no 0xAA). Pulse clr_err_i: both flags clear the next cycle. clr_err_i coincident with a new overflow leaves overflow_o=1.
- FWFT=0 and reset: write 0x5A, then read. rvalid_o pulses one cycle after rd_i with rdata_o=0x5A. Assert rst_i with count=7: next cycle count_o=0, empty_o=1, flags cleared, rvalid_o=0, and a following write/read returns the new data.
